mmapadd_sched: RTL and testbench
================================

# mmapadd_sched

Round-robin job scheduler that shares one `mMapAdd` accelerator core between `NREQ` requesters. Each requester submits a pair of `QTree_Int` root pointers (`m1`, `m2`). The block grants one job at a time and drives the core's `sourceGo`, `m1`, and `m2` input channels. It then collects the core's `Int` result and returns it to the owning requester. It sits between the host-side stream loaders and the core, replacing per-job wrapper sequencing.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (2..8).
- `PTR_W`, 17: pointer channel width; bit 0 is the valid flag.
- `RES_W`, 32: result channel width; bit 0 is the valid flag.
- `TIMEOUT`, 4095: watchdog limit in cycles (used only with `MMAPADD_SCHED_TIMEOUT_EN`).

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: job request, one bit per requester.
- `req_ready` out NREQ: one-hot job accept.
- `req_m1` in NREQ*PTR_W: first tree pointer; slice i belongs to requester i.
- `req_m2` in NREQ*PTR_W: second tree pointer; slice i belongs to requester i.
- `rsp_valid` out NREQ: one-hot result valid.
- `rsp_ready` in NREQ: result accept, one bit per requester.
- `rsp_data` out RES_W: result, shared by all requesters and qualified by `rsp_valid`.
- `rsp_err` out 1: timeout marker, qualified by `rsp_valid`.
- `core_go_d` out 1: Go token to the core.
- `core_go_r` in 1: ready for the Go token.
- `core_m1_d` out PTR_W: `m1` pointer to the core.
- `core_m1_r` in 1: ready for `m1`.
- `core_m2_d` out PTR_W: `m2` pointer to the core.
- `core_m2_r` in 1: ready for `m2`.
- `core_res_d` in RES_W: result from the core; bit 0 is valid.
- `core_res_r` out 1: result ready to the core.
- `busy` out 1: high whenever the state is not IDLE.
- `cur_owner` out $clog2(NREQ): index of the requester owning the current job.

## Operation
State machine: IDLE → ISSUE → WAIT → RESP → IDLE.

IDLE:
- `req_ready` is combinational: a one-hot grant to the first requester with `req_valid` set, searching round-robin starting at `last_grant+1`.
- No grant is given while `stale`=1.
- When the granted requester has `req_valid`=1, the block latches `m1`, `m2`, and the owner, then moves to ISSUE.

ISSUE:
- Three independent channels: Go, `m1`, `m2`.
- Each channel drives its payload with bit 0 = 1 until its `_r` is seen high; that transfers the item.
- From the next cycle that channel's bit 0 is 0 and its done flag is set.
- Pointer bits [PTR_W-1:1] are forwarded unchanged.
- When all three done flags are set, the done flags clear and the state moves to WAIT.

WAIT:
- `core_res_r`=1.
- When `core_res_d[0]`=1, the block captures `core_res_d` into `rsp_data` and moves to RESP.

RESP:
- `rsp_valid[owner]`=1; `rsp_data` is held.
- When `rsp_ready[owner]`=1, the block sets `last_grant`=owner, clears `rsp_valid` and `rsp_err`, and moves to IDLE.

Other rules:
- Requesters must hold `req_valid`, `m1`, and `m2` stable until accepted.
- Responses are never dropped; the scheduler stalls in RESP for as long as needed.
- `rsp_ready` bits of non-owners are ignored.

## Timing
Reset values (all outputs 0, plus internal state):
- `req_ready`, `rsp_valid`, `rsp_data`, `rsp_err`, `core_go_d`, `core_m1_d`, `core_m2_d`, `core_res_r`, `busy`, `cur_owner` = 0.
- State = IDLE, `stale`=0, `last_grant`=NREQ-1, so requester 0 wins first.

Latency, with the job accepted at cycle T:
- The core channels are valid at T+1.
- If all three `_r` are high at T+1, the state is WAIT at T+2 with `core_res_r`=1.
- A result present at T+2 gives `rsp_valid` at T+3.
- Minimum request-to-response latency is 3 cycles; back-to-back accept is possible in the cycle after the response handshake.

Boundary conditions:
- **Simultaneous requests:** round-robin order applies; all-requesters-valid with `last_grant`=0 grants 1.
- **Requests while busy:** `req_ready`=0, no loss.
- **Channel readies arriving on different cycles:** each channel completes independently; no channel re-sends.
- **Reset mid-job:** immediately returns to reset values; the core must be reset together with this block.

## Configuration
Macro `MMAPADD_SCHED_TIMEOUT_EN`:
- **Defined:**
  - A counter clears on entry to ISSUE and increments every cycle in ISSUE and WAIT.
  - When it reaches `TIMEOUT`, the state moves to RESP with `rsp_data`=0 and `rsp_err`=1, and `stale` is set.
  - While `stale`=1, `core_res_r`=1 in any state. The next `core_res_d[0]`=1 is consumed and discarded, which clears `stale`.
- **Undefined:** no counter and no stale logic, and `rsp_err` is tied to 0. WAIT is unbounded.

## Test plan
- Requester 0 only, `m1`=0x0003, `m2`=0x0005, all core readies high, core returns 0x0000002B (bit 0 set) at T+2 → `rsp_valid`=01 at T+3, `rsp_data`=0x0000002B, `rsp_err`=0.
- Both requesters valid from reset, each result accepted immediately → grant order 0,1,0,1; `cur_owner` follows it; no request is lost.
- `core_m2_r` delayed 5 cycles after Go and `m1` complete → exactly one transfer per channel, and WAIT is entered the cycle after the `m2` transfer.
- `rsp_ready` held low for 10 cycles in RESP → `rsp_data` stable, `req_ready` remains 0 for the new requester, release proceeds normally.
- Macro defined, `TIMEOUT`=16, core silent → `rsp_err`=1 and `rsp_data`=0 after 16 cycles. A late result is absorbed without a response. The next grant is withheld until the late result arrives.
- `reset` asserted during WAIT → all outputs 0 asynchronously; after release, requester 0 is granted first.

Source files
------------

// File: rtl/mmapadd_sched.sv
// rtl/mmapadd_sched.sv - round-robin scheduler sharing one mMapAdd core between NREQ requesters
// Optional watchdog and stale-result absorption: define MMAPADD_SCHED_TIMEOUT_EN.
module mmapadd_sched #(
  parameter int NREQ    = 2,
  parameter int PTR_W   = 17,
  parameter int RES_W   = 32,
  parameter int TIMEOUT = 4095
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*PTR_W-1:0]    req_m1,
  input  logic [NREQ*PTR_W-1:0]    req_m2,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [RES_W-1:0]         rsp_data,
  output logic                     rsp_err,
  output logic                     core_go_d,
  input  logic                     core_go_r,
  output logic [PTR_W-1:0]         core_m1_d,
  input  logic                     core_m1_r,
  output logic [PTR_W-1:0]         core_m2_d,
  input  logic                     core_m2_r,
  input  logic [RES_W-1:0]         core_res_d,
  output logic                     core_res_r,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  cur_owner
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t           state;
  logic [OW-1:0]    last_grant;
  logic [OW-1:0]    owner;
  logic [OW-1:0]    gnt_idx;
  logic             gnt_any;
  logic             accept;
  logic             stale;
  logic [PTR_W-1:0] m1_q;
  logic [PTR_W-1:0] m2_q;
  logic             go_done, m1_done, m2_done;
  logic             go_xfer, m1_xfer, m2_xfer;
  logic             issue_done;
  logic [NREQ-1:0]  owner_bit;

  // Round-robin search starting one past the last requester served.
  always_comb begin : rr_pick
    int          idx;
    logic [OW-1:0] idx_w;
    idx     = 0;
    idx_w   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx   = (int'(last_grant) + k) % NREQ;
      idx_w = OW'(idx);
      if (!gnt_any && req_valid[idx_w]) begin
        gnt_any = 1'b1;
        gnt_idx = idx_w;
      end
    end
  end

  assign accept = (state == IDLE) && !stale && gnt_any;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  assign go_xfer    = (state == ISSUE) && !go_done && core_go_r;
  assign m1_xfer    = (state == ISSUE) && !m1_done && core_m1_r;
  assign m2_xfer    = (state == ISSUE) && !m2_done && core_m2_r;
  assign issue_done = (go_done | go_xfer) & (m1_done | m1_xfer) & (m2_done | m2_xfer);

  assign core_go_d  = (state == ISSUE) && !go_done;
  assign core_m1_d  = {m1_q[PTR_W-1:1], (state == ISSUE) && !m1_done};
  assign core_m2_d  = {m2_q[PTR_W-1:1], (state == ISSUE) && !m2_done};
  assign core_res_r = (state == WAIT) || stale;
  assign busy       = (state != IDLE);
  assign cur_owner  = owner;
  assign owner_bit  = NREQ'(1) << owner;

`ifdef MMAPADD_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;
  logic          wd_fire;

  // A result landing on the final cycle of WAIT still wins over the watchdog.
  assign wd_fire = ((state == ISSUE) || ((state == WAIT) && !core_res_d[0]))
                   && (wd_cnt == CW'(TIMEOUT - 1));
`else
  assign stale   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= OW'(NREQ - 1);
      owner      <= '0;
      m1_q       <= '0;
      m2_q       <= '0;
      go_done    <= 1'b0;
      m1_done    <= 1'b0;
      m2_done    <= 1'b0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
`ifdef MMAPADD_SCHED_TIMEOUT_EN
      wd_cnt     <= '0;
      stale      <= 1'b0;
      rsp_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner <= gnt_idx;
            m1_q  <= req_m1[gnt_idx*PTR_W +: PTR_W];
            m2_q  <= req_m2[gnt_idx*PTR_W +: PTR_W];
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_done) begin
            go_done <= 1'b0;
            m1_done <= 1'b0;
            m2_done <= 1'b0;
            state   <= WAIT;
          end else begin
            go_done <= go_done | go_xfer;
            m1_done <= m1_done | m1_xfer;
            m2_done <= m2_done | m2_xfer;
          end
        end
        WAIT: begin
          if (core_res_d[0]) begin
            rsp_data  <= core_res_d;
            rsp_valid <= owner_bit;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            last_grant <= owner;
            rsp_valid  <= '0;
`ifdef MMAPADD_SCHED_TIMEOUT_EN
            rsp_err    <= 1'b0;
`endif
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef MMAPADD_SCHED_TIMEOUT_EN
      if (stale && core_res_d[0]) stale <= 1'b0;
      if (state == IDLE) wd_cnt <= '0;
      else if (state == ISSUE || state == WAIT) wd_cnt <= wd_cnt + 1'b1;
      // Abandon the job; the core's eventual answer is swallowed via stale.
      if (wd_fire) begin
        state     <= RESP;
        rsp_data  <= '0;
        rsp_err   <= 1'b1;
        rsp_valid <= owner_bit;
        stale     <= 1'b1;
        go_done   <= 1'b0;
        m1_done   <= 1'b0;
        m2_done   <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mmapadd_sched.sv
// tb/tb_mmapadd_sched.sv - self-checking bench for mmapadd_sched with a behavioural core model
module tb_mmapadd_sched;
  localparam int NREQ  = 2;
  localparam int PTR_W = 17;
  localparam int RES_W = 32;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NREQ-1:0]         req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*PTR_W-1:0]   req_m1, req_m2;
  logic [RES_W-1:0]        rsp_data, core_res_d;
  logic                    rsp_err, core_go_d, core_go_r, core_m1_r, core_m2_r, core_res_r, busy;
  logic [PTR_W-1:0]        core_m1_d, core_m2_d;
  logic [0:0]              cur_owner;

  int errors = 0;
  int checks = 0;

  mmapadd_sched #(.NREQ(NREQ), .PTR_W(PTR_W), .RES_W(RES_W), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_m1(req_m1), .req_m2(req_m2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_go_d(core_go_d), .core_go_r(core_go_r),
    .core_m1_d(core_m1_d), .core_m1_r(core_m1_r),
    .core_m2_d(core_m2_d), .core_m2_r(core_m2_r),
    .core_res_d(core_res_d), .core_res_r(core_res_r),
    .busy(busy), .cur_owner(cur_owner)
  );

  always #5 clk = ~clk;

  // Stand-in for the accelerator: any deterministic function of both pointers.
  function automatic logic [31:0] core_fn(logic [16:0] a, logic [16:0] b);
    logic [30:0] v;
    v = 31'(a[16:1]) * 31'd3 + 31'(b[16:1]);
    return {v, 1'b1};
  endfunction

  function automatic int rr_pick(int last, logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    req_valid = '0; req_m1 = '0; req_m2 = '0; rsp_ready = '0;
    core_go_r = 1'b0; core_m1_r = 1'b0; core_m2_r = 1'b0; core_res_d = '0;
  endtask

  task automatic apply_reset;
    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    drive_idle();
    reset = 1'b1;
    tick();
    checks++;
    if ({req_ready, rsp_valid, rsp_err, busy, cur_owner} !== '0) begin
      errors++;
      $display("FAIL reset_ctl: got rr=%b rv=%b err=%b busy=%b own=%0d want all 0",
               req_ready, rsp_valid, rsp_err, busy, cur_owner);
    end
    checks++;
    if (rsp_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", rsp_data); end
    checks++;
    if ({core_go_d, core_m1_d, core_m2_d, core_res_r} !== '0) begin
      errors++;
      $display("FAIL reset_core: got go=%b m1=%h m2=%h rr=%b want 0", core_go_d, core_m1_d, core_m2_d, core_res_r);
    end
    reset = 1'b0;
    tick();
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant: got %b want 01", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_single;
    apply_reset();
    req_valid = 2'b01;
    req_m1[0 +: PTR_W] = 17'h3;
    req_m2[0 +: PTR_W] = 17'h5;
    core_go_r = 1'b1; core_m1_r = 1'b1; core_m2_r = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", req_ready); end
    tick();
    req_valid = '0;
    checks++;
    if ({core_go_d, core_m1_d, core_m2_d} !== {1'b1, 17'h3, 17'h5}) begin
      errors++;
      $display("FAIL single_issue: got go=%b m1=%h m2=%h want 1 00003 00005", core_go_d, core_m1_d, core_m2_d);
    end
    tick();
    checks++;
    if ({core_res_r, core_go_d, core_m1_d[0], core_m2_d[0], busy} !== 5'b10001) begin
      errors++;
      $display("FAIL single_wait: got res_r=%b go=%b v1=%b v2=%b busy=%b want 1 0 0 0 1",
               core_res_r, core_go_d, core_m1_d[0], core_m2_d[0], busy);
    end
    core_res_d = 32'h0000_002B;
    tick();
    core_res_d = '0;
    checks++;
    if ({rsp_valid, rsp_data, rsp_err} !== {2'b01, 32'h0000_002B, 1'b0}) begin
      errors++;
      $display("FAIL single_rsp: got v=%b d=%h e=%b want 01 0000002b 0", rsp_valid, rsp_data, rsp_err);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;
    checks++;
    if ({rsp_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL single_release: got v=%b busy=%b want 00 0", rsp_valid, busy);
    end
  endtask

  task automatic test_m2_delay;
    int go_n, m1_n, m2_n;
    go_n = 0; m1_n = 0; m2_n = 0;
    req_valid = 2'b10;
    req_m1[PTR_W +: PTR_W] = 17'h0ABC;
    req_m2[PTR_W +: PTR_W] = 17'h1235;
    core_go_r = 1'b1; core_m1_r = 1'b1; core_m2_r = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL delay_grant: got %b want 10", req_ready); end
    tick();
    req_valid = '0;
    for (int c = 0; c < 7; c++) begin
      core_m2_r = (c == 6);
      #1;
      if (core_go_d && core_go_r) go_n++;
      if (core_m1_d[0] && core_m1_r) m1_n++;
      if (core_m2_d[0] && core_m2_r) m2_n++;
      checks++;
      if (core_res_r !== 1'b0 || core_m2_d[0] !== 1'b1) begin
        errors++;
        $display("FAIL delay_issue c=%0d: got res_r=%b v2=%b want 0 1", c, core_res_r, core_m2_d[0]);
      end
      tick();
    end
    checks++;
    if ({core_res_r, core_go_d, core_m1_d[0], core_m2_d[0]} !== 4'b1000) begin
      errors++;
      $display("FAIL delay_wait: got res_r=%b go=%b v1=%b v2=%b want 1 0 0 0",
               core_res_r, core_go_d, core_m1_d[0], core_m2_d[0]);
    end
    checks++;
    if ({go_n, m1_n, m2_n} !== {32'd1, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL delay_xfers: got go=%0d m1=%0d m2=%0d want 1 1 1", go_n, m1_n, m2_n);
    end
    core_res_d = core_fn(17'h0ABC, 17'h1235);
    tick();
    core_res_d = '0;
    checks++;
    if ({rsp_valid, rsp_data} !== {2'b10, core_fn(17'h0ABC, 17'h1235)}) begin
      errors++;
      $display("FAIL delay_rsp: got v=%b d=%h want 10 %h", rsp_valid, rsp_data, core_fn(17'h0ABC, 17'h1235));
    end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = '0;
  endtask

  task automatic test_resp_stall;
    logic [31:0] res;
    res = {$urandom, 1'b1};
    req_valid = 2'b01;
    core_go_r = 1'b1; core_m1_r = 1'b1; core_m2_r = 1'b1;
    tick();
    req_valid = '0;
    tick();
    core_res_d = res;
    tick();
    core_res_d = '0;
    req_valid  = 2'b11;
    rsp_ready  = 2'b10;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_data, req_ready} !== {2'b01, res, 2'b00}) begin
        errors++;
        $display("FAIL stall c=%0d: got v=%b d=%h rr=%b want 01 %h 00", c, rsp_valid, rsp_data, req_ready, res);
      end
      tick();
    end
    rsp_ready = 2'b01;
    req_valid = '0;
    tick();
    rsp_ready = '0;
    req_valid = 2'b11;
    #1;
    checks++;
    if ({busy, req_ready} !== 3'b010) begin
      errors++;
      $display("FAIL stall_release: got busy=%b rr=%b want 0 10", busy, req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [PTR_W-1:0] pm1 [NREQ];
    logic [PTR_W-1:0] pm2 [NREQ];
    logic [PTR_W-1:0] jm1, jm2, cm1, cm2;
    logic [NREQ-1:0]  exp_oh;
    int model_last, job, jobs, go_n, m1_n, m2_n, res_cnt, acc_req, cyc;
    bit in_job, armed, seen_rsp, rel;
    apply_reset();
    model_last = NREQ - 1;
    jobs = 0; in_job = 0; armed = 0; rel = 0; acc_req = -1; job = 0;
    go_n = 0; m1_n = 0; m2_n = 0; res_cnt = 0; seen_rsp = 0;
    jm1 = '0; jm2 = '0; cm1 = '0; cm2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      pm1[i] = 17'($urandom); pm2[i] = 17'($urandom);
      req_m1[i*PTR_W +: PTR_W] = pm1[i]; req_m2[i*PTR_W +: PTR_W] = pm2[i];
    end
    req_valid = '1;
    for (cyc = 0; cyc < 4000 && jobs < 24; cyc++) begin
      if (rel) begin in_job = 0; rel = 0; end
      for (int i = 0; i < NREQ; i++) begin
        if (i == acc_req || (!req_valid[i] && $urandom_range(0, 1) == 1)) begin
          pm1[i] = 17'($urandom); pm2[i] = 17'($urandom);
          req_m1[i*PTR_W +: PTR_W] = pm1[i]; req_m2[i*PTR_W +: PTR_W] = pm2[i];
          req_valid[i] = (jobs < 6) || ($urandom_range(0, 3) != 0);
        end
      end
      acc_req    = -1;
      core_res_d = (armed && res_cnt == 0) ? core_fn(cm1, cm2) : '0;
      core_go_r  = $urandom_range(0, 3) != 0;
      core_m1_r  = $urandom_range(0, 3) != 0;
      core_m2_r  = $urandom_range(0, 3) != 0;
      rsp_ready  = NREQ'($urandom);
      #1;
      if (!in_job) begin
        job = rr_pick(model_last, req_valid);
        exp_oh = (job < 0) ? '0 : NREQ'(1) << job;
        checks++;
        if (req_ready !== exp_oh) begin
          errors++;
          $display("FAIL rr_grant cyc=%0d: got %b want %b", cyc, req_ready, exp_oh);
        end
        if (job >= 0) begin
          in_job = 1; acc_req = job; jm1 = pm1[job]; jm2 = pm2[job];
          go_n = 0; m1_n = 0; m2_n = 0; armed = 0; seen_rsp = 0;
        end
      end else begin
        checks++;
        if (req_ready !== '0 || busy !== 1'b1 || cur_owner !== 1'(job)) begin
          errors++;
          $display("FAIL rr_busy cyc=%0d: got rr=%b busy=%b own=%0d want 00 1 %0d", cyc, req_ready, busy, cur_owner, job);
        end
        if (core_go_d && core_go_r) go_n++;
        if (core_m1_d[0] && core_m1_r) begin m1_n++; cm1 = core_m1_d; end
        if (core_m2_d[0] && core_m2_r) begin m2_n++; cm2 = core_m2_d; end
        if (armed && core_res_d[0] && core_res_r) armed = 0;
        else if (armed && res_cnt > 0) res_cnt--;
        if (!armed && !seen_rsp && core_res_d[0] == 1'b0 && go_n > 0 && m1_n > 0 && m2_n > 0
            && rsp_valid == '0 && !core_res_r) begin
          armed = 1; res_cnt = $urandom_range(0, 3);
        end
        if (rsp_valid !== '0) begin
          if (!seen_rsp) begin
            seen_rsp = 1;
            exp_oh = NREQ'(1) << job;
            checks++;
            if ({rsp_valid, rsp_data, rsp_err} !== {exp_oh, core_fn(jm1, jm2), 1'b0}) begin
              errors++;
              $display("FAIL rr_rsp job=%0d: got v=%b d=%h e=%b want %b %h 0",
                       jobs, rsp_valid, rsp_data, rsp_err, exp_oh, core_fn(jm1, jm2));
            end
            checks++;
            if (go_n != 1 || m1_n != 1 || m2_n != 1) begin
              errors++;
              $display("FAIL rr_xfers job=%0d: got go=%0d m1=%0d m2=%0d want 1 1 1", jobs, go_n, m1_n, m2_n);
            end
          end
          if (rsp_ready[job]) begin rel = 1; model_last = job; jobs++; end
        end
      end
      tick();
    end
    checks++;
    if (jobs < 24) begin errors++; $display("FAIL rr_budget: got %0d jobs want 24", jobs); end
    drive_idle();
    repeat (6) tick();
  endtask

  task automatic test_reset_mid;
    apply_reset();
    req_valid = 2'b10;
    core_go_r = 1'b1; core_m1_r = 1'b1; core_m2_r = 1'b1;
    tick();
    req_valid = '0;
    tick();
    checks++;
    if ({core_res_r, cur_owner} !== 2'b11) begin
      errors++;
      $display("FAIL mid_wait: got res_r=%b own=%0d want 1 1", core_res_r, cur_owner);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, core_go_d, core_m1_d, core_m2_d, core_res_r, busy, cur_owner} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b res_r=%b own=%0d want all 0", busy, core_res_r, cur_owner);
    end
    tick();
    reset = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_regrant: got %b want 01", req_ready); end
    req_valid = '0;
    tick();
  endtask

`ifdef MMAPADD_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    apply_reset();
    req_valid = 2'b01;
    core_go_r = 1'b1; core_m1_r = 1'b1; core_m2_r = 1'b1;
    tick();
    req_valid = '0;
    n = 1;
    while (rsp_valid == '0 && n < 60) begin tick(); n++; end
    checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {2'b01, 1'b1, 32'h0} || n != 17) begin
      errors++;
      $display("FAIL timeout_rsp: got v=%b e=%b d=%h after %0d want 01 1 0 after 17", rsp_valid, rsp_err, rsp_data, n);
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = '0;
    req_valid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({req_ready, core_res_r} !== 3'b001) begin
        errors++;
        $display("FAIL timeout_stale c=%0d: got rr=%b res_r=%b want 00 1", c, req_ready, core_res_r);
      end
      tick();
    end
    core_res_d = 32'h1234_5679;
    tick();
    core_res_d = '0;
    #1;
    checks++;
    if ({rsp_valid, req_ready} !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_absorb: got v=%b rr=%b want 00 10", rsp_valid, req_ready);
    end
    req_valid = '0;
    tick();
  endtask
`endif

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_single();
    test_m2_delay();
    test_resp_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef MMAPADD_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
